// File: rtl/ads1115_pkg.sv
// ads1115_pkg: shared definitions for the ADS1115 single-shot sequencer.
//   - I2C engine micro-op encodings
//   - ADS1115 register pointer values and comparator-disable field
//   - FSM state enums for the sequencer and the op issuer
//   - cfg_word(): builds the 16-bit config register value for one conversion
package ads1115_pkg;

  typedef enum logic [1:0] {
    I2cStart = 2'd0,
    I2cStop  = 2'd1,
    I2cRead  = 2'd2,
    I2cWrite = 2'd3
  } i2c_instr_e;

  localparam logic [7:0] PTR_CONV     = 8'h00;
  localparam logic [7:0] PTR_CONFIG   = 8'h01;
  localparam logic [4:0] COMP_DISABLE = 5'b00011;

  // Op list indices with special follow-up behaviour
  localparam logic [3:0] OP_CFG_STOP  = 4'd5;
  localparam logic [3:0] OP_PTR_START = 4'd6;
  localparam logic [3:0] OP_RD_HI     = 4'd12;
  localparam logic [3:0] OP_RD_LO     = 4'd13;
  localparam logic [3:0] OP_LAST      = 4'd14;

  typedef enum logic [2:0] {
    StSettle,
    StIdle,
    StRun,
    StConvWait,
    StDone
  } seq_state_e;

  typedef enum logic [1:0] {
    IssIdle,
    IssIssue,
    IssWait,
    IssRelease
  } iss_state_e;

  // OS=1 starts a conversion, MUX={1,ch} selects single-ended AINch, MODE=1 is single-shot.
  function automatic logic [15:0] cfg_word(input logic [1:0] channel, input logic [2:0] pga,
                                           input logic [2:0] data_rate);
    return {1'b1, 1'b1, channel, pga, 1'b1, data_rate, COMP_DISABLE};
  endfunction

endpackage

// File: rtl/i2c_op_issuer.sv
// i2c_op_issuer: runs one I2C engine micro-op per accepted request.
//   ISSUE drives the op with enable=1, WAIT holds it until the engine reports complete,
//   RELEASE drops enable for one cycle so the engine returns to idle. A new request may be
//   accepted in IDLE or directly in RELEASE (back-to-back ops).
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_op_valid              request an op (accepted in IDLE or RELEASE)
//   i_instruction, i_byte   op to issue, latched on acceptance
//   o_op_done               1-cycle pulse in RELEASE
//   o_rx_byte               byte captured when the engine completes
//   o_i2c_*/i_i2c_*         engine interface
module i2c_op_issuer
  import ads1115_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_op_valid,
  input  i2c_instr_e i_instruction,
  input  logic [7:0] i_byte,
  output logic       o_op_done,
  output logic [7:0] o_rx_byte,
  output logic [1:0] o_i2c_instruction,
  output logic       o_i2c_enable,
  output logic [7:0] o_i2c_byte_to_send,
  input  logic [7:0] i_i2c_byte_received,
  input  logic       i_i2c_complete
);

  iss_state_e r_state, w_next;
  i2c_instr_e r_instr;
  logic [7:0] r_byte;
  logic [7:0] r_rx;
  logic       w_accept;

  assign w_accept = i_op_valid && ((r_state == IssIdle) || (r_state == IssRelease));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IssIdle;
    else         r_state <= w_next;
  end

  // complete is never sampled in ISSUE: it is still high from the previous op there.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IssIdle:    if (i_op_valid) w_next = IssIssue;
      IssIssue:   w_next = IssWait;
      IssWait:    if (i_i2c_complete) w_next = IssRelease;
      IssRelease: w_next = i_op_valid ? IssIssue : IssIdle;
      default:    w_next = IssIdle;
    endcase
  end

  always_comb begin
    o_i2c_enable = (r_state == IssIssue) || (r_state == IssWait);
    o_op_done    = (r_state == IssRelease);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_instr <= I2cStop;
      r_byte  <= 8'h00;
      r_rx    <= 8'h00;
    end else begin
      if (w_accept) begin
        r_instr <= i_instruction;
        r_byte  <= i_byte;
      end
      if ((r_state == IssWait) && i_i2c_complete) r_rx <= i_i2c_byte_received;
    end
  end

  assign o_i2c_instruction  = r_instr;
  assign o_i2c_byte_to_send = r_byte;
  assign o_rx_byte          = r_rx;

endmodule

// File: rtl/ads1115_sequencer.sv
// ads1115_sequencer: one ADS1115 single-shot conversion per accepted start.
//   Writes the config register, waits out the conversion, points at the conversion register,
//   reads two bytes and presents them as a 16-bit sample.
// Ports:
//   i_clk, i_reset           clock, async active-high reset
//   i_start, i_channel       conversion request (only while idle), AIN0..3 select
//   o_busy                   high from acceptance (or reset) until the sample is presented
//   o_sample, o_sample_valid last result, 1-cycle valid pulse on update
//   o_i2c_*/i_i2c_*          byte-level I2C engine interface
module ads1115_sequencer
  import ads1115_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR         = 7'h48,
  parameter logic [2:0]  PGA              = 3'b001,
  parameter logic [2:0]  DATA_RATE        = 3'b100,
  parameter int unsigned CONV_WAIT_CYCLES = 250000,
  parameter int unsigned SETTLE_CYCLES    = 2048
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_channel,
  output logic        o_busy,
  output logic [15:0] o_sample,
  output logic        o_sample_valid,
  output logic [1:0]  o_i2c_instruction,
  output logic        o_i2c_enable,
  output logic [7:0]  o_i2c_byte_to_send,
  input  logic [7:0]  i_i2c_byte_received,
  input  logic        i_i2c_complete
);

  localparam logic [17:0] CONV_LAST   = 18'(CONV_WAIT_CYCLES - 1);
  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYCLES - 1);

  seq_state_e  r_state, w_next;
  logic [3:0]  r_op_idx;
  logic [1:0]  r_channel;
  logic [17:0] r_conv_cnt;
  logic [11:0] r_settle_cnt;
  logic [7:0]  r_hi, r_lo;
  logic [15:0] r_sample;

  logic        w_start_ok, w_conv_exp, w_settle_exp, w_op_done, w_op_valid;
  logic [3:0]  w_op_sel;
  logic [15:0] w_cfg;
  i2c_instr_e  w_op_instr;
  logic [7:0]  w_op_byte;
  logic [7:0]  w_rx_byte;

  assign w_start_ok   = (r_state == StIdle) && i_start;
  assign w_conv_exp   = (r_state == StConvWait) && (r_conv_cnt == CONV_LAST);
  assign w_settle_exp = (r_state == StSettle) && (r_settle_cnt == SETTLE_LAST);

  // In RUN a new op is requested in the RELEASE cycle of the previous one, so it is the
  // following entry that must be presented to the issuer.
  assign w_op_sel   = (r_state == StRun) ? r_op_idx + 4'd1 : r_op_idx;
  assign w_op_valid = w_start_ok || w_conv_exp ||
                      ((r_state == StRun) && w_op_done &&
                       (r_op_idx != OP_CFG_STOP) && (r_op_idx != OP_LAST));
  assign w_cfg      = cfg_word(r_channel, PGA, DATA_RATE);

  always_comb begin
    w_op_instr = I2cStop;
    w_op_byte  = 8'h00;
    case (w_op_sel)
      4'd0, 4'd6, 4'd10: w_op_instr = I2cStart;
      4'd1, 4'd7:        begin w_op_instr = I2cWrite; w_op_byte = {I2C_ADDR, 1'b0}; end
      4'd2:              begin w_op_instr = I2cWrite; w_op_byte = PTR_CONFIG;      end
      4'd3:              begin w_op_instr = I2cWrite; w_op_byte = w_cfg[15:8];     end
      4'd4:              begin w_op_instr = I2cWrite; w_op_byte = w_cfg[7:0];      end
      4'd8:              begin w_op_instr = I2cWrite; w_op_byte = PTR_CONV;        end
      4'd11:             begin w_op_instr = I2cWrite; w_op_byte = {I2C_ADDR, 1'b1}; end
      4'd12, 4'd13:      w_op_instr = I2cRead;
      default:           w_op_instr = I2cStop;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StSettle;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      StSettle:   if (w_settle_exp) w_next = StIdle;
      StIdle:     if (i_start) w_next = StRun;
      StRun: begin
        if (w_op_done && (r_op_idx == OP_CFG_STOP)) w_next = StConvWait;
        else if (w_op_done && (r_op_idx == OP_LAST)) w_next = StDone;
      end
      StConvWait: if (w_conv_exp) w_next = StRun;
      StDone:     w_next = StIdle;
      default:    w_next = StSettle;
    endcase
  end

  always_comb begin
    o_busy         = !((r_state == StIdle) || (r_state == StDone));
    o_sample_valid = (r_state == StDone);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op_idx     <= 4'd0;
      r_channel    <= 2'd0;
      r_conv_cnt   <= 18'd0;
      r_settle_cnt <= 12'd0;
      r_hi         <= 8'h00;
      r_lo         <= 8'h00;
      r_sample     <= 16'h0000;
    end else begin
      r_settle_cnt <= ((r_state == StSettle) && !w_settle_exp) ? r_settle_cnt + 12'd1 : 12'd0;
      r_conv_cnt   <= ((r_state == StConvWait) && !w_conv_exp) ? r_conv_cnt + 18'd1 : 18'd0;
      if (w_start_ok) r_channel <= i_channel;

      if (w_op_valid) r_op_idx <= w_op_sel;
      else if ((r_state == StRun) && w_op_done && (r_op_idx == OP_CFG_STOP))
        r_op_idx <= OP_PTR_START;
      else if (r_state == StDone) r_op_idx <= 4'd0;

      if ((r_state == StRun) && w_op_done) begin
        if (r_op_idx == OP_RD_HI) r_hi <= w_rx_byte;
        if (r_op_idx == OP_RD_LO) r_lo <= w_rx_byte;
        if (r_op_idx == OP_LAST)  r_sample <= {r_hi, r_lo};
      end
    end
  end

  assign o_sample = r_sample;

  i2c_op_issuer u_issuer (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_op_valid          (w_op_valid),
    .i_instruction       (w_op_instr),
    .i_byte              (w_op_byte),
    .o_op_done           (w_op_done),
    .o_rx_byte           (w_rx_byte),
    .o_i2c_instruction   (o_i2c_instruction),
    .o_i2c_enable        (o_i2c_enable),
    .o_i2c_byte_to_send  (o_i2c_byte_to_send),
    .i_i2c_byte_received (i_i2c_byte_received),
    .i_i2c_complete      (i_i2c_complete)
  );

endmodule

// File: tb/tb_ads1115_sequencer.sv
// Bench for ads1115_sequencer with a behavioural byte-level I2C engine.
module tb_ads1115_sequencer;

  localparam int unsigned CONV   = 16;
  localparam int unsigned SETTLE = 32;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  channel;
  logic        busy, valid, en;
  logic [15:0] sample;
  logic [1:0]  instr;
  logic [7:0]  tx;
  logic [7:0]  rx = 8'h00;
  logic        complete = 1'b0;

  always #5 clk = ~clk;

  ads1115_sequencer #(
    .CONV_WAIT_CYCLES (CONV),
    .SETTLE_CYCLES    (SETTLE)
  ) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_start             (start),
    .i_channel           (channel),
    .o_busy              (busy),
    .o_sample            (sample),
    .o_sample_valid      (valid),
    .o_i2c_instruction   (instr),
    .o_i2c_enable        (en),
    .o_i2c_byte_to_send  (tx),
    .i_i2c_byte_received (rx),
    .i_i2c_complete      (complete)
  );

  typedef struct packed {
    logic [1:0] instr;
    logic [7:0] data;
    logic       follow;  // next op is issued right after the 1-cycle release
  } op_t;

  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  cfg_hi;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] smp;
  } vec_t;

  op_t         exp_ops[$];
  logic [7:0]  rd_q[$];
  logic [15:0] smp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: starts an op when it sees enable while idle, raises complete after a short
  // latency and keeps it high until enable has gone low.
  int         eng_st = 0;
  int         eng_cnt = 0;
  int         eng_ops = 0;
  bit         gap_chk = 0;
  bit         aborted = 0;
  logic [1:0] cur_instr;
  bit         cur_follow;
  logic [7:0] rx_val;

  always @(negedge clk) begin
    op_t o;
    if (gap_chk) begin
      gap_chk = 0;
      check("release_gap_one_cycle", en, 1);
    end
    case (eng_st)
      0: if (en) begin
        eng_ops++;
        cur_instr  = instr;
        cur_follow = 0;
        if (exp_ops.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_op: got instr %0d, expected none (t=%0t)", instr, $time);
        end else begin
          o = exp_ops.pop_front();
          cur_follow = o.follow;
          check("op_instr", instr, o.instr);
          if (o.instr == 2'd3) check("op_byte", tx, o.data);
        end
        if (instr == 2'd2 && rd_q.size() > 0) rx_val = rd_q.pop_front();
        else rx_val = 8'hFF;
        complete = 1'b0;
        eng_cnt  = 1 + (eng_ops % 3);
        eng_st   = 1;
      end
      1: begin
        if (!aborted) check("enable_held_until_complete", en, 1);
        if (eng_cnt == 0) begin
          complete = 1'b1;
          if (cur_instr == 2'd2) rx = rx_val;
          eng_st = 2;
        end else begin
          eng_cnt--;
        end
      end
      default: if (!en) begin
        eng_st = 0;
        if (cur_follow && !aborted) gap_chk = 1;
        aborted = 0;
      end
    endcase
  end

  // Sample scoreboard and pulse-width monitor
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (prev_valid) check("valid_one_cycle", valid, 0);
    if (valid) begin
      check("busy_low_at_valid", busy, 0);
      if (smp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0h, expected none", sample);
      end else begin
        check("sample", sample, smp_q.pop_front());
      end
    end
    prev_valid = valid;
  end

  task automatic push_op(input logic [1:0] i, input logic [7:0] d, input logic f);
    op_t o;
    o.instr = i; o.data = d; o.follow = f;
    exp_ops.push_back(o);
  endtask

  task automatic push_conv(input vec_t v);
    push_op(2'd0, 8'h00, 1); push_op(2'd3, 8'h90, 1); push_op(2'd3, 8'h01, 1);
    push_op(2'd3, v.cfg_hi, 1); push_op(2'd3, 8'h83, 1); push_op(2'd1, 8'h00, 0);
    push_op(2'd0, 8'h00, 1); push_op(2'd3, 8'h90, 1); push_op(2'd3, 8'h00, 1);
    push_op(2'd1, 8'h00, 1);
    push_op(2'd0, 8'h00, 1); push_op(2'd3, 8'h91, 1); push_op(2'd2, 8'h00, 1);
    push_op(2'd2, 8'h00, 1); push_op(2'd1, 8'h00, 0);
    rd_q.push_back(v.hi);
    rd_q.push_back(v.lo);
    smp_q.push_back(v.smp);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 1);
    check("rst_sample", sample, 0);
    check("rst_valid", valid, 0);
    check("rst_enable", en, 0);
    check("rst_instr", instr, 1);
    check("rst_byte", tx, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (valid) got = 1;
    end
    check("valid_timeout", got, 1);
  endtask

  task automatic begin_conv(input vec_t v);
    wait_idle();
    push_conv(v);
    channel = v.ch;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    channel = ~v.ch;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_conv(input vec_t v);
    begin_conv(v);
    wait_valid();
    @(negedge clk);
    check("ops_consumed", exp_ops.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t v;
    int   base;
    bit   hit;

    vecs[0] = '{ch: 2'd1, cfg_hi: 8'hD3, hi: 8'h12, lo: 8'h34, smp: 16'h1234};
    vecs[1] = '{ch: 2'd0, cfg_hi: 8'hC3, hi: 8'h80, lo: 8'h00, smp: 16'h8000};
    vecs[2] = '{ch: 2'd2, cfg_hi: 8'hE3, hi: 8'hFF, lo: 8'hFF, smp: 16'hFFFF};
    vecs[3] = '{ch: 2'd3, cfg_hi: 8'hF3, hi: 8'h7F, lo: 8'hFE, smp: 16'h7FFE};

    // Reset and settle: a start during SETTLE is dropped
    reset = 1'b1; start = 1'b0; channel = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin start = 1'b1; channel = 2'd2; end
      if (k == 5) start = 1'b0;
      if (k == 31) check("busy_before_settle_end", busy, 1);
      if (k == 32) check("busy_after_settle_end", busy, 0);
    end
    repeat (20) @(negedge clk);
    check("no_engine_op_after_ignored_start", eng_ops, 0);

    // Table-driven conversions
    foreach (vecs[i]) run_conv(vecs[i]);

    // Reset during op 12 (first read)
    v = '{ch: 2'd2, cfg_hi: 8'hE3, hi: 8'h55, lo: 8'hAA, smp: 16'h55AA};
    base = eng_ops;
    begin_conv(v);
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (eng_ops == base + 13 && eng_st == 1) hit = 1;
    end
    check("reached_op12", hit, 1);
    aborted = 1;
    gap_chk = 0;
    reset   = 1'b1;
    #1;
    check("enable_low_async", en, 0);
    exp_ops.delete();
    rd_q.delete();
    smp_q.delete();
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    base  = eng_ops;
    run_conv(vecs[3]);
    check("full_sequence_after_reset", eng_ops - base, 15);

    // Starts while busy and in the DONE cycle are ignored
    v = '{ch: 2'd0, cfg_hi: 8'hC3, hi: 8'hA5, lo: 8'h5A, smp: 16'hA55A};
    base = eng_ops;
    begin_conv(v);
    repeat (2) @(negedge clk);
    check("busy_before_pulse1", busy, 1);
    start = 1'b1; channel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_before_pulse2", busy, 1);
    start = 1'b1; channel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    start = 1'b1; channel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("single_conversion", eng_ops - base, 15);
    check("idle_after_single", busy, 0);
    check("ops_consumed_single", exp_ops.size(), 0);
    check("samples_consumed", smp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
